pd_block_load_ctrl: RTL and testbench
=====================================

# pd_block_load_ctrl

Sequencer for the 112-byte header/difficulty storage. It accepts the header stream byte by byte from the USB-side byte source and writes each byte into storage at addresses 0..111. It then launches the SHA-256 core and, after each miss, pulses the storage's nonce-increment path and relaunches the core. This repeats until a hit, the try budget is exhausted, or the host aborts. It sits between the USB receive FIFO, the block storage and the hash core.

## Interface
Parameters:
- MAX_TRIES, 1024: number of hash attempts per loaded header before giving up (≥1).
- TRY_W, 32: width of try counter; must hold MAX_TRIES.

Ports:
- clk  in  1  system clock; all state on rising edge.
- rst  in  1  reset; **asynchronous, active-high** (already decided).
- start  in  1  one-cycle request to begin a new load; honoured only in IDLE, FOUND, EXHAUSTED.
- abort  in  1  return to IDLE from any state.
- in_valid  in  1  byte-source data valid.
- in_data  in  8  header byte, in address order 0..111.
- in_ready  out  1  controller accepts a byte this cycle.
- store_en  out  1  storage write enable.
- store_sel  out  7  storage byte address.
- store_data  out  8  storage write byte.
- nonce_inc  out  1  one-cycle nonce-increment pulse to storage.
- hash_start  out  1  one-cycle hash launch pulse.
- hash_done  in  1  hash core result valid (one cycle).
- hash_hit  in  1  qualifies hash_done: result met difficulty.
- busy  out  1  state not in IDLE/FOUND/EXHAUSTED.
- found  out  1  level; high in FOUND.
- exhausted  out  1  level; high in EXHAUSTED.
- tries  out  TRY_W  attempts completed for current header.

## Operation
- States: IDLE, LOAD, FLUSH, HASH, WAIT, INC, FOUND, EXHAUSTED.
- IDLE/FOUND/EXHAUSTED: start → LOAD; byte counter and tries cleared to 0.
- LOAD: in_ready=1. Byte accepted when in_valid&in_ready. Each accept registers store_en=1, store_sel=count, store_data=in_data for the next cycle; count++. Accepting byte 111 → FLUSH.
- FLUSH: last store write visible; in_ready=0 → HASH.
- HASH: hash_start=1 for exactly this cycle → WAIT.
- WAIT: hash_done&hash_hit → FOUND, tries++. If hash_done&!hash_hit, tries++; then go to EXHAUSTED if tries+1==MAX_TRIES, else to INC. hash_hit ignored without hash_done.
- INC: nonce_inc=1 for exactly this cycle → HASH.
- store_en, hash_start and nonce_inc are never high simultaneously.
- tries saturates at MAX_TRIES; never wraps.
- abort has priority over every transition, including start and hash_done in the same cycle. The next state is IDLE and all pulse outputs drop. tries and the counter hold until the next start.
- start outside IDLE/FOUND/EXHAUSTED is ignored.
- Bytes offered while in_ready=0 are not consumed.

## Timing
- Reset (async assert): state IDLE. in_ready, store_en, store_sel, store_data, nonce_inc, hash_start, busy, found and exhausted are 0; tries=0; count=0. Reset mid-load or mid-hash discards progress.
- start at cycle t → in_ready=1 at t+1.
- Byte accepted at cycle k → store_en=1 with its address/data at k+1. Back-to-back accepts give back-to-back writes, one byte per cycle.
- Last byte accepted at t → store write at t+1 (FLUSH), hash_start at t+2.
- Miss via hash_done at d → nonce_inc at d+1, hash_start at d+2, tries updated at d+1.
- Hit at d → found=1 from d+1, held until start or abort.
- Minimum load time 113 cycles from first accept to hash_start−1.

## Test plan
- Reset mid-LOAD after 50 bytes → all outputs 0 immediately. A new start plus 112 bytes (value = address) writes sel 0..111 with data 0..111; hash_start fires 2 cycles after the last accept.
- Stall stream: in_valid toggles every other cycle → store_en only on cycles after accepts; no duplicate or skipped addresses; final sel=111.
- Three misses then hit (MAX_TRIES=8) → exactly 3 nonce_inc pulses, 4 hash_start pulses, found=1, tries=4, busy=0.
- MAX_TRIES=4, all misses → 3 nonce_inc pulses, exhausted=1, tries=4, no fifth hash_start.
- abort in the same cycle as hash_done&hash_hit → IDLE, found=0, no nonce_inc. start while in WAIT → ignored.
- hash_hit=1 with hash_done=0 in WAIT → remains in WAIT, no state change.

Source files
------------

// File: rtl/pd_block_load_ctrl.sv
// pd_block_load_ctrl: loads the 112-byte header into block storage, then drives
// the hash/nonce-increment retry loop until a hit, try exhaustion or abort.
`default_nettype none

module pd_block_load_ctrl #(
  parameter int MAX_TRIES = 1024,
  parameter int TRY_W     = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic             in_valid,
  input  logic [7:0]       in_data,
  output logic             in_ready,
  output logic             store_en,
  output logic [6:0]       store_sel,
  output logic [7:0]       store_data,
  output logic             nonce_inc,
  output logic             hash_start,
  input  logic             hash_done,
  input  logic             hash_hit,
  output logic             busy,
  output logic             found,
  output logic             exhausted,
  output logic [TRY_W-1:0] tries
);

  typedef enum logic [2:0] {
    S_IDLE      = 3'd0,
    S_LOAD      = 3'd1,
    S_FLUSH     = 3'd2,
    S_HASH      = 3'd3,
    S_WAIT      = 3'd4,
    S_INC       = 3'd5,
    S_FOUND     = 3'd6,
    S_EXHAUSTED = 3'd7
  } state_t;

  localparam logic [TRY_W-1:0] MAX_T     = TRY_W'(MAX_TRIES);
  localparam logic [6:0]       LAST_BYTE = 7'd111;

  state_t           state_q, state_d;
  logic [6:0]       count_q, count_d;
  logic [TRY_W-1:0] tries_q, tries_d;
  logic             store_en_q, store_en_d;
  logic [6:0]       store_sel_q, store_sel_d;
  logic [7:0]       store_data_q, store_data_d;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q      <= S_IDLE;
      count_q      <= 7'd0;
      tries_q      <= '0;
      store_en_q   <= 1'b0;
      store_sel_q  <= 7'd0;
      store_data_q <= 8'd0;
    end else begin
      state_q      <= state_d;
      count_q      <= count_d;
      tries_q      <= tries_d;
      store_en_q   <= store_en_d;
      store_sel_q  <= store_sel_d;
      store_data_q <= store_data_d;
    end
  end

  always_comb begin
    state_d      = state_q;
    count_d      = count_q;
    tries_d      = tries_q;
    store_en_d   = 1'b0;
    store_sel_d  = store_sel_q;
    store_data_d = store_data_q;
    in_ready     = 1'b0;
    hash_start   = 1'b0;
    nonce_inc    = 1'b0;

    // Abort overrides everything; progress counters are kept until the next start.
    if (abort) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE, S_FOUND, S_EXHAUSTED: begin
          if (start) begin
            state_d = S_LOAD;
            count_d = 7'd0;
            tries_d = '0;
          end
        end
        S_LOAD: begin
          in_ready = 1'b1;
          if (in_valid) begin
            store_en_d   = 1'b1;
            store_sel_d  = count_q;
            store_data_d = in_data;
            count_d      = count_q + 7'd1;
            if (count_q == LAST_BYTE) state_d = S_FLUSH;
          end
        end
        S_FLUSH: state_d = S_HASH;
        S_HASH: begin
          hash_start = 1'b1;
          state_d    = S_WAIT;
        end
        S_WAIT: begin
          if (hash_done) begin
            if (tries_q < MAX_T) tries_d = tries_q + TRY_W'(1);
            if (hash_hit)            state_d = S_FOUND;
            else if (tries_d >= MAX_T) state_d = S_EXHAUSTED;
            else                     state_d = S_INC;
          end
        end
        S_INC: begin
          nonce_inc = 1'b1;
          state_d   = S_HASH;
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  assign store_en   = store_en_q;
  assign store_sel  = store_sel_q;
  assign store_data = store_data_q;
  assign tries      = tries_q;
  assign found      = (state_q == S_FOUND);
  assign exhausted  = (state_q == S_EXHAUSTED);
  assign busy       = !(state_q == S_IDLE || state_q == S_FOUND || state_q == S_EXHAUSTED);

endmodule

`default_nettype wire

// File: tb/tb_pd_block_load_ctrl.sv
// tb_pd_block_load_ctrl: scoreboarded header loads plus a table of hash-phase
// scenarios, followed by hand-written reset and abort sequences.
`default_nettype none

module tb_pd_block_load_ctrl;
  localparam int MAX_TRIES = 4;
  localparam int TRY_W     = 8;

  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             start = 1'b0;
  logic             abort = 1'b0;
  logic             in_valid = 1'b0;
  logic [7:0]       in_data = 8'd0;
  logic             hash_done = 1'b0;
  logic             hash_hit = 1'b0;
  logic             in_ready, store_en, nonce_inc, hash_start, busy, found, exhausted;
  logic [6:0]       store_sel;
  logic [7:0]       store_data;
  logic [TRY_W-1:0] tries;

  always #5 clk = ~clk;

  pd_block_load_ctrl #(.MAX_TRIES(MAX_TRIES), .TRY_W(TRY_W)) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort),
    .in_valid(in_valid), .in_data(in_data), .in_ready(in_ready),
    .store_en(store_en), .store_sel(store_sel), .store_data(store_data),
    .nonce_inc(nonce_inc), .hash_start(hash_start),
    .hash_done(hash_done), .hash_hit(hash_hit),
    .busy(busy), .found(found), .exhausted(exhausted), .tries(tries)
  );

  typedef struct packed {
    logic [6:0] sel;
    logic [7:0] data;
  } exp_t;

  typedef struct {
    int misses;
    int exp_starts;
    int exp_nonce;
    bit exp_found;
    bit exp_exh;
    int exp_tries;
  } vec_t;

  int   checks = 0;
  int   failures = 0;
  int   cyc = 0;
  exp_t sb[$];
  int   ex_addr = 0;
  int   hs_cnt = 0;
  int   nonce_cnt = 0;
  int   last_acc_cyc = -1;
  int   first_hs_cyc = -1;
  int   last_done_cyc = -10;
  bit   prev_nonce = 1'b0;
  bit   resp_en = 1'b0;
  int   resp_delay = -1;
  int   resp_att = 0;
  int   resp_misses = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0d required %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic monitor();
    exp_t e;
    int   n;
    if (in_valid && in_ready) begin
      sb.push_back('{sel: 7'(ex_addr), data: in_data});
      ex_addr++;
      if (ex_addr == 112) last_acc_cyc = cyc;
    end
    if (store_en) begin
      if (sb.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL store_unexpected: got write sel=%0d, required no write", store_sel);
      end else begin
        e = sb.pop_front();
        chk("store_sel", store_sel, e.sel);
        chk("store_data", store_data, e.data);
      end
    end
    if (store_en || hash_start || nonce_inc) begin
      n = int'(store_en) + int'(hash_start) + int'(nonce_inc);
      chk("pulse_exclusive", n, 1);
    end
    if (prev_nonce) chk("hash_after_inc", hash_start, 1'b1);
    if (nonce_inc) begin
      nonce_cnt++;
      chk("inc_after_done", cyc, last_done_cyc + 1);
    end
    if (hash_start) begin
      hs_cnt++;
      if (first_hs_cyc < 0) first_hs_cyc = cyc;
      if (resp_en) resp_delay = 2;
    end
    if (hash_done) last_done_cyc = cyc;
    prev_nonce = nonce_inc;
  endtask

  // One clock: sample at negedge, then move to just after the next rising edge.
  task automatic step();
    @(negedge clk);
    monitor();
    @(posedge clk);
    cyc++;
    #1;
    if (resp_en) begin
      hash_done = 1'b0;
      hash_hit  = (resp_delay == 1);
      if (resp_delay == 0) begin
        hash_done = 1'b1;
        hash_hit  = (resp_att >= resp_misses);
        resp_att++;
      end
      if (resp_delay >= 0) resp_delay--;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_in_ready"}, in_ready, 0);
    chk({tag, "_store_en"}, store_en, 0);
    chk({tag, "_store_sel"}, store_sel, 0);
    chk({tag, "_store_data"}, store_data, 0);
    chk({tag, "_nonce_inc"}, nonce_inc, 0);
    chk({tag, "_hash_start"}, hash_start, 0);
    chk({tag, "_busy"}, busy, 0);
    chk({tag, "_found"}, found, 0);
    chk({tag, "_exhausted"}, exhausted, 0);
    chk({tag, "_tries"}, tries, 0);
  endtask

  task automatic do_start();
    ex_addr = 0;
    sb.delete();
    first_hs_cyc = -1;
    start = 1'b1;
    step();
    start = 1'b0;
    chk("in_ready_after_start", in_ready, 1);
  endtask

  task automatic load(input int nbytes, input bit stall, input logic [7:0] pat);
    int n = 0;
    while (ex_addr < nbytes && n < 1000) begin
      in_valid = stall ? (cyc % 2 == 0) : 1'b1;
      in_data  = 8'(ex_addr) ^ pat;
      step();
      n++;
    end
    in_valid = 1'b0;
    if (ex_addr < nbytes) begin
      checks++;
      failures++;
      $display("FAIL load_timeout: got %0d bytes accepted, required %0d", ex_addr, nbytes);
    end
  endtask

  task automatic run_hash(input vec_t v);
    int n = 0;
    resp_en = 1'b1;
    resp_att = 0;
    resp_misses = v.misses;
    resp_delay = -1;
    hs_cnt = 0;
    nonce_cnt = 0;
    while (!(found || exhausted) && n < 300) begin
      step();
      n++;
    end
    if (!(found || exhausted)) begin
      checks++;
      failures++;
      $display("FAIL hash_timeout: got found=%0d exhausted=%0d, required a terminal state", found, exhausted);
    end
    repeat (6) step();
    resp_en = 1'b0;
    hash_done = 1'b0;
    hash_hit = 1'b0;
    chk("hash_starts", hs_cnt, v.exp_starts);
    chk("nonce_pulses", nonce_cnt, v.exp_nonce);
    chk("found", found, v.exp_found);
    chk("exhausted", exhausted, v.exp_exh);
    chk("tries", tries, v.exp_tries);
    chk("busy_end", busy, 0);
    chk("hs_after_last_byte", first_hs_cyc - last_acc_cyc, 2);
    chk("sb_drained", sb.size(), 0);
    chk("final_sel", store_sel, 111);
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation did not complete, required termination");
    $fatal(1, "watchdog");
  end

  vec_t vecs[4];

  initial begin
    int n;
    vecs[0] = '{misses: 3,  exp_starts: 4, exp_nonce: 3, exp_found: 1'b1, exp_exh: 1'b0, exp_tries: 4};
    vecs[1] = '{misses: 0,  exp_starts: 1, exp_nonce: 0, exp_found: 1'b1, exp_exh: 1'b0, exp_tries: 1};
    vecs[2] = '{misses: 1,  exp_starts: 2, exp_nonce: 1, exp_found: 1'b1, exp_exh: 1'b0, exp_tries: 2};
    vecs[3] = '{misses: 99, exp_starts: 4, exp_nonce: 3, exp_found: 1'b0, exp_exh: 1'b1, exp_tries: 4};

    repeat (2) @(posedge clk);
    #1;
    chk_all_zero("reset");
    rst = 1'b0;
    step();

    // Reset in the middle of a load must clear everything at once.
    do_start();
    load(50, 1'b0, 8'h00);
    rst = 1'b1;
    #1;
    chk_all_zero("midload_rst");
    step();
    rst = 1'b0;
    sb.delete();
    step();
    chk_all_zero("after_rst");

    for (int i = 0; i < 4; i++) begin
      do_start();
      load(112, (i == 1), (i == 0) ? 8'h00 : 8'(8'h5A + i));
      run_hash(vecs[i]);
    end

    // Abort coinciding with a hit; start and a bare hash_hit in WAIT are ignored.
    do_start();
    load(112, 1'b0, 8'h33);
    hs_cnt = 0;
    nonce_cnt = 0;
    n = 0;
    while (hs_cnt == 0 && n < 20) begin
      step();
      n++;
    end
    chk("manual_hash_start", hs_cnt, 1);
    hash_hit = 1'b1;
    hash_done = 1'b0;
    repeat (3) step();
    chk("hit_wo_done_busy", busy, 1);
    chk("hit_wo_done_found", found, 0);
    chk("hit_wo_done_nonce", nonce_cnt, 0);
    start = 1'b1;
    step();
    start = 1'b0;
    chk("start_in_wait_ready", in_ready, 0);
    chk("start_in_wait_busy", busy, 1);
    hash_done = 1'b1;
    hash_hit = 1'b1;
    abort = 1'b1;
    step();
    hash_done = 1'b0;
    hash_hit = 1'b0;
    abort = 1'b0;
    chk("abort_found", found, 0);
    chk("abort_busy", busy, 0);
    chk("abort_exhausted", exhausted, 0);
    chk("abort_tries_hold", tries, 0);
    repeat (4) step();
    chk("abort_no_nonce", nonce_cnt, 0);
    chk("abort_no_restart", hs_cnt, 1);
    chk("abort_idle_found", found, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

`default_nettype wire
